// File: rtl/adder_pipe.sv
// Elastic integer add/sub/slt execute unit: result computed at acceptance,
// then carried through STAGES valid/ready register stages to writeback.
module adder_pipe #(
  parameter int XLEN   = 64,
  parameter int RB     = 2,
  parameter int STAGES = 2
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic                           flush,
  input  logic                           exeparam_valid,
  output logic                           exeparam_ready,
  input  logic [1:0]                     op,
  input  logic                           is32,
  input  logic [4+RB:0]                  rd0_in,
  input  logic [XLEN-1:0]                op1,
  input  logic [XLEN-1:0]                op2,
  output logic                           writeback_valid,
  input  logic                           writeback_ready,
  output logic [XLEN-1:0]                res_qout,
  output logic [4+RB:0]                  rd0_qout,
  output logic [$clog2(STAGES+1)-1:0]    occupancy
);

  localparam int TW = 5 + RB;
  localparam int OW = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("adder_pipe: STAGES must be in 1..4");
  end

  // op[1] selects compare vs arithmetic; op[0] selects sub / unsigned compare.
  function automatic logic [XLEN-1:0] alu_result(
    input logic [1:0]      f_op,
    input logic            f_is32,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0]    b_eff;
    logic [XLEN-1:0]    sum;
    logic signed [31:0] sum_w;
    logic [XLEN-1:0]    sum_ext;
    logic               lt_s;
    logic               lt_u;
    b_eff   = f_op[0] ? ~b : b;
    sum     = a + b_eff + XLEN'(f_op[0]);
    sum_w   = sum[31:0];
    sum_ext = XLEN'(sum_w);
    if (f_is32) begin
      lt_s = $signed(a[31:0]) < $signed(b[31:0]);
      lt_u = a[31:0] < b[31:0];
    end else begin
      lt_s = $signed(a) < $signed(b);
      lt_u = a < b;
    end
    if (f_op[1]) alu_result = XLEN'(f_op[0] ? lt_u : lt_s);
    else if (f_is32) alu_result = sum_ext;
    else alu_result = sum;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] adv;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [XLEN-1:0]   res_d [STAGES];
  logic [TW-1:0]     tag_q [STAGES];
  logic [TW-1:0]     tag_d [STAGES];
  logic              accept;
  logic [OW-1:0]     occ_cnt;

  // Advance chain runs from the writeback end back to S1, so ready is
  // combinational from writeback_ready.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = writeback_ready | ~vld_q[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~vld_q[i] | adv[i+1];
    end
    exeparam_ready = adv[0] & ~flush;
    accept         = exeparam_valid & exeparam_ready;
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < STAGES; i++) begin
      res_d[i] = res_q[i];
      tag_d[i] = tag_q[i];
    end
    if (adv[0]) begin
      vld_d[0] = accept;
      res_d[0] = alu_result(op, is32, op1, op2);
      tag_d[0] = rd0_in;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv[i]) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
    // Flush kills validity only; stale data in the registers is harmless.
    if (flush) vld_d = '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= res_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_cnt = occ_cnt + OW'(vld_q[i]);
    end
  end

  assign occupancy       = occ_cnt;
  assign writeback_valid = vld_q[STAGES-1];
  assign res_qout        = res_q[STAGES-1];
  assign rd0_qout        = tag_q[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Randomized and directed bench for adder_pipe against an in-order queue model.
module tb_adder_pipe;

  localparam int XLEN   = 64;
  localparam int RB     = 2;
  localparam int STAGES = 2;
  localparam int TW     = 5 + RB;
  localparam int OW     = $clog2(STAGES + 1);

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            flush = 1'b0;
  logic            exeparam_valid = 1'b0;
  logic            exeparam_ready;
  logic [1:0]      op = 2'd0;
  logic            is32 = 1'b0;
  logic [TW-1:0]   rd0_in = '0;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            writeback_valid;
  logic            writeback_ready = 1'b1;
  logic [XLEN-1:0] res_qout;
  logic [TW-1:0]   rd0_qout;
  logic [OW-1:0]   occupancy;

  int checks = 0;
  int failures = 0;
  int completed = 0;
  logic [63:0]   exp_res[$];
  logic [TW-1:0] exp_tag[$];

  adder_pipe #(.XLEN(XLEN), .RB(RB), .STAGES(STAGES)) dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .exeparam_valid(exeparam_valid), .exeparam_ready(exeparam_ready),
    .op(op), .is32(is32), .rd0_in(rd0_in), .op1(op1), .op2(op2),
    .writeback_valid(writeback_valid), .writeback_ready(writeback_ready),
    .res_qout(res_qout), .rd0_qout(rd0_qout), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [1:0] f_op, input logic f_is32,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] w;
    logic [63:0] r;
    case (f_op)
      2'd0: begin
        w = a[31:0] + b[31:0];
        r = f_is32 ? {{32{w[31]}}, w} : a + b;
      end
      2'd1: begin
        w = a[31:0] - b[31:0];
        r = f_is32 ? {{32{w[31]}}, w} : a - b;
      end
      2'd2: r = f_is32 ? 64'($signed(a[31:0]) < $signed(b[31:0])) : 64'($signed(a) < $signed(b));
      default: r = f_is32 ? 64'(a[31:0] < b[31:0]) : 64'(a < b);
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] f_op, input logic f_is32,
                       input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] tag);
    exeparam_valid = v;
    op = f_op;
    is32 = f_is32;
    op1 = a;
    op2 = b;
    rd0_in = tag;
  endtask

  // One clock: compare outputs against the model at the falling edge, then
  // update the model with this cycle's handshakes and step past the rising edge.
  task automatic cycle();
    logic exp_ready;
    @(negedge CLK);
    exp_ready = !flush && (exp_res.size() < STAGES || writeback_ready);
    check("ready", 64'(exeparam_ready), 64'(exp_ready));
    check("occupancy", 64'(occupancy), 64'(exp_res.size()));
    if (writeback_valid) begin
      if (exp_res.size() == 0) begin
        check("wb_spurious", 64'(writeback_valid), 64'd0);
      end else begin
        check("wb_res", res_qout, exp_res[0]);
        check("wb_tag", 64'(rd0_qout), 64'(exp_tag[0]));
        if (writeback_ready) begin
          void'(exp_res.pop_front());
          void'(exp_tag.pop_front());
          completed++;
        end
      end
    end
    if (flush) begin
      exp_res.delete();
      exp_tag.delete();
    end else if (exeparam_valid && exeparam_ready) begin
      exp_res.push_back(ref_alu(op, is32, op1, op2));
      exp_tag.push_back(rd0_in);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] f_op, input logic f_is32,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] expv);
    writeback_ready = 1'b1;
    drive(1'b1, f_op, f_is32, a, b, 7'h2A);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 7'h00);
    cycle();
    check({name, "_valid"}, 64'(writeback_valid), 64'd1);
    check(name, res_qout, expv);
    cycle();
  endtask

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 16));
      2: case ($urandom_range(0, 5))
           0: v = 64'h0;
           1: v = 64'h1;
           2: v = 64'hFFFF_FFFF_FFFF_FFFF;
           3: v = 64'h0000_0000_8000_0000;
           4: v = 64'h0000_0000_7FFF_FFFF;
           default: v = 64'h8000_0000_0000_0000;
         endcase
      default: v = {32'($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0), $urandom};
    endcase
    return v;
  endfunction

  initial begin
    int done_before;
    #12;
    check("rst_wb_valid", 64'(writeback_valid), 64'd0);
    check("rst_res", res_qout, 64'd0);
    check("rst_rd0", 64'(rd0_qout), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_ready", 64'(exeparam_ready), 64'd1);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // Basic latency: add 5+7 visible two cycles after acceptance.
    writeback_ready = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 64'd5, 64'd7, 7'h11);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 7'h00);
    check("lat_c1_valid", 64'(writeback_valid), 64'd0);
    check("lat_c1_occ", 64'(occupancy), 64'd1);
    cycle();
    check("lat_c2_valid", 64'(writeback_valid), 64'd1);
    check("lat_c2_res", res_qout, 64'd12);
    check("lat_c2_rd0", 64'(rd0_qout), 64'h11);
    check("lat_c2_occ", 64'(occupancy), 64'd1);
    cycle();

    run_op("subw", 2'd1, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("addw", 2'd0, 1'b1, 64'h0000_0001_7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("slt", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    run_op("sltu", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    run_op("sltw", 2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'd1);
    run_op("sub", 2'd1, 1'b0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("sltuw", 2'd3, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 64'd1);

    // Backpressure: third op held off, then full pipeline shifts and accepts.
    done_before = completed;
    writeback_ready = 1'b0;
    drive(1'b1, 2'd0, 1'b0, 64'd100, 64'd1, 7'h01);
    cycle();
    drive(1'b1, 2'd0, 1'b0, 64'd200, 64'd2, 7'h02);
    cycle();
    drive(1'b1, 2'd0, 1'b0, 64'd300, 64'd3, 7'h03);
    #1;
    check("bp_ready_full", 64'(exeparam_ready), 64'd0);
    check("bp_occ_full", 64'(occupancy), 64'd2);
    cycle();
    writeback_ready = 1'b1;
    #1;
    check("bp_ready_release", 64'(exeparam_ready), 64'd1);
    cycle();
    check("bp_occ_shift", 64'(occupancy), 64'd2);
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 7'h00);
    repeat (3) cycle();
    check("bp_drained", 64'(completed - done_before), 64'd3);

    // Flush with two ops in flight and a valid op presented in the flush cycle.
    drive(1'b1, 2'd0, 1'b0, 64'd10, 64'd1, 7'h04);
    cycle();
    drive(1'b1, 2'd0, 1'b0, 64'd20, 64'd1, 7'h05);
    cycle();
    drive(1'b1, 2'd0, 1'b0, 64'd999, 64'd1, 7'h3F);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 7'h00);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_wb_valid", 64'(writeback_valid), 64'd0);
    repeat (3) cycle();

    // Asynchronous reset between edges with a full pipeline.
    writeback_ready = 1'b0;
    drive(1'b1, 2'd1, 1'b0, 64'd50, 64'd8, 7'h06);
    cycle();
    drive(1'b1, 2'd0, 1'b0, 64'd60, 64'd9, 7'h07);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 7'h00);
    #2;
    RSTn = 1'b0;
    #1;
    check("arst_wb_valid", 64'(writeback_valid), 64'd0);
    check("arst_res", res_qout, 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    exp_res.delete();
    exp_tag.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    run_op("post_rst_add", 2'd0, 1'b0, 64'd40, 64'd2, 64'd42);

    // Randomized traffic with random backpressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            pick_operand(), pick_operand(), 7'($urandom_range(0, 127)));
      writeback_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end

    flush = 1'b0;
    writeback_ready = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 7'h00);
    repeat (STAGES + 2) cycle();
    check("final_empty", 64'(exp_res.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
